// File: rtl/mux_scan_ctrl.sv
// Round-robin select sequencer for a 4:1 mux stage.
// Steps {s1,s0} over channels 0..3, holds each channel for DWELL cycles so the
// mux output can settle, samples y on the last dwell cycle and publishes a
// 4-bit snapshot with a one-cycle done pulse after every full sweep.
// Handshake: start is a level sampled only in IDLE; busy is high for the whole
// sweep; done is a single-cycle pulse that coincides with the capture update.
module mux_scan_ctrl #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic       stop,
    input  logic       y,
    output logic       s1,
    output logic       s0,
    output logic       sample,
    output logic       busy,
    output logic       done,
    output logic [3:0] capture
);

    // Dwell counter is at least one bit wide so DWELL=1 still elaborates.
    localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state;
    logic [1:0]  ch;
    logic [CW-1:0] cnt;
    logic [3:0]  shadow;
    logic        mode_l;
    logic        stop_req;
    logic        last_dwell;

    // Last cycle of the current channel's dwell window.
    assign last_dwell = (cnt == CNT_LAST);

    // Select lines, busy and sample all follow directly from registered state.
    always_comb begin
        s1     = ch[1];
        s0     = ch[0];
        busy   = (state == SCAN);
        sample = (state == SCAN) && last_dwell;
    end

    // Sweep FSM: channel stepping, y capture, sweep completion and stop handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ch       <= 2'd0;
            cnt      <= '0;
            shadow   <= 4'd0;
            capture  <= 4'd0;
            done     <= 1'b0;
            mode_l   <= 1'b0;
            stop_req <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // stop is meaningless here; only start is looked at.
                    if (start) begin
                        state    <= SCAN;
                        ch       <= 2'd0;
                        cnt      <= '0;
                        mode_l   <= mode;
                        stop_req <= 1'b0;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        stop_req <= 1'b1;
                    end
                    if (last_dwell) begin
                        shadow[ch] <= y;
                        cnt        <= '0;
                        if (ch != 2'd3) begin
                            ch <= ch + 2'd1;
                        end else begin
                            // Final channel: y goes straight into the snapshot
                            // since shadow[3] is not yet updated this edge.
                            capture <= {y, shadow[2:0]};
                            done    <= 1'b1;
                            ch      <= 2'd0;
                            if (!(mode_l && !stop_req && !stop)) begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ch    <= 2'd0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one instance with DWELL=4, one with DWELL=1.
// Each instance scans a modelled 4:1 mux whose inputs are a bench pattern.
module tb_mux_scan_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DWELL=4 instance signals
    logic       start, mode, stop, y;
    logic       s1, s0, sample, busy, done;
    logic [3:0] capture;
    logic [3:0] pat;

    // DWELL=1 instance signals
    logic       start1, mode1, stop1, y1;
    logic       s1_1, s0_1, sample1, busy1, done1;
    logic [3:0] capture1;
    logic [3:0] pat1;

    // Mux models: y is the pattern bit addressed by the select lines.
    assign y  = pat[{s1, s0}];
    assign y1 = pat1[{s1_1, s0_1}];

    mux_scan_ctrl #(.DWELL(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .stop(stop), .y(y),
        .s1(s1), .s0(s0), .sample(sample), .busy(busy), .done(done),
        .capture(capture)
    );

    mux_scan_ctrl #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .stop(stop1), .y(y1),
        .s1(s1_1), .s0(s0_1), .sample(sample1), .busy(busy1), .done(done1),
        .capture(capture1)
    );

    // ---------------- scoreboard ----------------
    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       start;
        logic       mode;
        logic       stop;
        logic [1:0] sel;
        logic       busy;
        logic       sample;
        logic       done;
        logic [3:0] cap;
    } vec_t;

    vec_t vec[18];

    int done_cnt;

    initial begin
        rst = 1'b1; start = 0; mode = 0; stop = 0; pat = 4'b0000;
        start1 = 0; mode1 = 0; stop1 = 0; pat1 = 4'b0000;

        // Single sweep, DWELL=4, mux inputs 1010. Entry i = outputs after edge k+i.
        // Mode toggled mid-sweep and stop raised in IDLE must both be ignored.
        //          start mode stop sel  busy samp done cap
        vec[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0};
        vec[1]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0};
        vec[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0};
        vec[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'h0};
        vec[4]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 4'h0};
        vec[5]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 4'h0};
        vec[6]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 4'h0};
        vec[7]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 4'h0};
        vec[8]  = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 4'h0};
        vec[9]  = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 4'h0};
        vec[10] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 4'h0};
        vec[11] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 4'h0};
        vec[12] = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 4'h0};
        vec[13] = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 4'h0};
        vec[14] = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 4'h0};
        vec[15] = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 4'h0};
        vec[16] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'hA};
        vec[17] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'hA};

        // ---- 1: reset held 2 cycles then released ----
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_sel",     {6'd0, s1, s0}, 8'h0);
        check("rst_busy",    {7'd0, busy}, 8'h0);
        check("rst_done",    {7'd0, done}, 8'h0);
        check("rst_capture", {4'd0, capture}, 8'h0);
        check("rst_sample",  {7'd0, sample}, 8'h0);
        check("rst_busy1",   {7'd0, busy1}, 8'h0);
        check("rst_cap1",    {4'd0, capture1}, 8'h0);

        // ---- 2: table-driven single sweep ----
        pat = 4'b1010;
        for (int i = 0; i < 18; i++) begin
            start = vec[i].start;
            mode  = vec[i].mode;
            stop  = vec[i].stop;
            tick();
            check($sformatf("t2_sel[%0d]", i),    {6'd0, s1, s0}, {6'd0, vec[i].sel});
            check($sformatf("t2_busy[%0d]", i),   {7'd0, busy},   {7'd0, vec[i].busy});
            check($sformatf("t2_sample[%0d]", i), {7'd0, sample}, {7'd0, vec[i].sample});
            check($sformatf("t2_done[%0d]", i),   {7'd0, done},   {7'd0, vec[i].done});
            check($sformatf("t2_cap[%0d]", i),    {4'd0, capture}, {4'd0, vec[i].cap});
        end
        start = 0; mode = 0; stop = 0;
        tick();

        // ---- 3: continuous mode, pattern change between sweeps, stop in sweep 2 ----
        pat = 4'b1010;
        start = 1; mode = 1;
        tick();                       // edge k
        start = 0; mode = 0;
        done_cnt = 0;
        for (int j = 1; j <= 44; j++) begin
            stop = (j == 24);
            tick();                   // edge k+j
            if (done) done_cnt++;
            if (j == 16) begin
                check("t3_done16", {7'd0, done}, 8'h1);
                check("t3_cap16",  {4'd0, capture}, 8'h0A);
                check("t3_busy16", {7'd0, busy}, 8'h1);
                pat = 4'b0101;
            end
            if (j == 32) begin
                check("t3_done32", {7'd0, done}, 8'h1);
                check("t3_cap32",  {4'd0, capture}, 8'h05);
                check("t3_busy32", {7'd0, busy}, 8'h0);
            end
        end
        stop = 0;
        check("t3_done_count", done_cnt[7:0], 8'd2);
        check("t3_idle_end",   {7'd0, busy}, 8'h0);
        check("t3_cap_end",    {4'd0, capture}, 8'h05);

        // ---- 4: start re-pulsed mid-sweep is ignored ----
        pat = 4'b0011;
        start = 1;
        tick();                       // edge k
        start = 0;
        done_cnt = 0;
        for (int j = 1; j <= 22; j++) begin
            start = (j == 5);
            tick();
            if (done) done_cnt++;
            if (j == 15) check("t4_busy15", {7'd0, busy}, 8'h1);
            if (j == 16) begin
                check("t4_done16", {7'd0, done}, 8'h1);
                check("t4_cap16",  {4'd0, capture}, 8'h03);
            end
        end
        start = 0;
        check("t4_done_count", done_cnt[7:0], 8'd1);

        // ---- 5: reset mid-sweep aborts; new start sweeps normally ----
        pat = 4'b1100;
        start = 1;
        tick();                       // edge k
        start = 0;
        for (int j = 1; j <= 8; j++) tick();
        rst = 1;
        tick();                       // edge k+9
        rst = 0;
        check("t5_busy",    {7'd0, busy}, 8'h0);
        check("t5_cap",     {4'd0, capture}, 8'h0);
        check("t5_sel",     {6'd0, s1, s0}, 8'h0);
        check("t5_done",    {7'd0, done}, 8'h0);
        done_cnt = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (done) done_cnt++;
        end
        check("t5_no_done", done_cnt[7:0], 8'd0);
        start = 1;
        tick();
        start = 0;
        done_cnt = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (done) done_cnt++;
            if (j == 16) begin
                check("t5_done16", {7'd0, done}, 8'h1);
                check("t5_cap16",  {4'd0, capture}, 8'h0C);
            end
        end
        check("t5_done_count", done_cnt[7:0], 8'd1);

        // ---- 6: DWELL=1 samples every cycle, sweep in 4 cycles ----
        pat1 = 4'b0110;
        start1 = 1;
        tick();                       // edge k
        start1 = 0;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t6_sample[%0d]", j), {7'd0, sample1}, 8'h1);
            check($sformatf("t6_sel[%0d]", j), {6'd0, s1_1, s0_1}, 8'(j));
            check($sformatf("t6_done[%0d]", j), {7'd0, done1}, 8'h0);
            tick();                   // edge k+j+1
        end
        check("t6_done4",   {7'd0, done1}, 8'h1);
        check("t6_cap4",    {4'd0, capture1}, 8'h06);
        check("t6_busy4",   {7'd0, busy1}, 8'h0);
        check("t6_sample4", {7'd0, sample1}, 8'h0);
        tick();
        check("t6_done5",   {7'd0, done1}, 8'h0);

        // ---- report ----
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
